wiscsc15_fetch: RTL and testbench
=================================

# wiscsc15_fetch

Instruction fetch unit for the WISC-SC15 core. It sits between instruction memory and the opcode decode stage, and supplies the 16-bit instruction words whose upper nibble drives the control decoder. It owns the PC and issues in-order memory requests under a credit limit. It buffers returned words in a small FIFO, presents them to decode with a valid/ready handshake, and handles redirects (branch, call, ret) and the HLT opcode.

## Interface
- `PC_W`, 16: PC and instruction-address width (word addressed; PC advances by 1 per instruction).
- `RESET_PC`, 16'h0000: first fetch address after reset.
- `BUF_DEPTH`, 4: instruction FIFO depth and maximum credits (in-flight + buffered). Must be a power of two, ≥2.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out PC_W: fetch address; valid with `imem_req`.
- `imem_ready` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: read data valid. At most one per cycle, in request order, ≥1 cycle after acceptance.
- `imem_rdata` in 16: returned instruction word.
- `instr_valid` out 1: `instr`/`instr_pc` hold a valid instruction.
- `instr` out 16: instruction word; `instr[15:12]` is the opcode.
- `instr_pc` out PC_W: address of `instr`.
- `instr_ready` in 1: decode consumes the instruction this cycle.
- `redirect` in 1: branch taken, call, or ret resolved. Restart fetch at `redirect_pc`.
- `redirect_pc` in PC_W: new fetch address.
- `halted` out 1: HLT consumed; fetch stopped.

## Operation
- States: RUN, HALT. Reset enters RUN with `fetch_pc=RESET_PC`, FIFO empty, `inflight=0`, `drop=0`.
- Request rule: `imem_req = RUN && !redirect && (inflight + count < BUF_DEPTH)`, where both counts are registered values. `imem_req` is forced 0 while `rst_n` is low.
- `imem_addr` always equals `fetch_pc`.
- Request accepted (`imem_req && imem_ready`): `fetch_pc` increments by 1 (wraps modulo 2^PC_W) and `inflight` increments.
- Response (`imem_rvalid`): `inflight` decrements.
  - If `drop>0`: the word is discarded and `drop` decrements.
  - Otherwise the word and its PC are pushed into the FIFO. Response PC is tracked by a response-PC counter that advances on each non-dropped response.
- The FIFO head drives `instr`/`instr_pc`, registered. `instr_valid = count>0`. A pop occurs on `instr_valid && instr_ready`.
- Redirect (RUN only):
  - Next `fetch_pc` = `redirect_pc`; the response-PC counter is also set to `redirect_pc`.
  - FIFO is flushed (`count=0` next cycle).
  - `drop` becomes the total outstanding count after this cycle's accept and response: `inflight + accept − rvalid`. Any same-cycle response is discarded.
  - A same-cycle pop completes normally; that is the redirecting instruction.
- HLT: when an instruction with opcode 4'b1111 is popped, enter HALT.
  - FIFO is flushed and outstanding responses go to `drop`.
  - `imem_req=0` and `halted=1` until reset.
  - Redirects are ignored in HALT.
  - Responses still drain and are discarded.
- Redirect and HLT pop in the same cycle: HALT wins.
- Overflow cannot occur by construction. An `imem_rvalid` with `inflight==0` is a protocol error: assert in simulation, ignore in RTL.

## Timing
- Reset values: `imem_req=0`, `imem_addr=RESET_PC`, `instr_valid=0`, `instr=16'h0000`, `instr_pc=0`, `halted=0`.
- First request in the first cycle after `rst_n` deasserts.
- Latency: request accepted at cycle N, response at cycle N+k (k≥1), `instr_valid` at N+k+1.
- Sustained throughput is 1 instruction/cycle with k=1, `imem_ready=1` and `instr_ready=1` (requires `BUF_DEPTH≥3`).
- Redirect at cycle R:
  - `imem_req=0` in cycle R.
  - First request to `redirect_pc` in R+1, subject to credits.
  - `instr_valid=0` in R+1.
- `instr`/`instr_pc` hold stable while `instr_valid && !instr_ready`.
- Reset asserted mid-operation: all state clears immediately. Responses to pre-reset requests are the memory's responsibility to squash.

## Test plan
- Streaming: k=1, ready always high, memory returns `mem[a]=a`. Require `instr_pc`/`instr` = 0,1,2,3… on consecutive cycles from cycle 2 after reset.
- Backpressure: `instr_ready=0` for 10 cycles. Require exactly 4 requests issued, `instr` held at PC 0, no loss or duplication after release.
- Redirect with 2 in flight (k=3): `redirect_pc=16'h0040`. Require the two stale responses dropped, next `instr_pc=16'h0040`, `16'h0041`.
- Redirect coincident with a pop and a response: the popped instruction is delivered once, the response is discarded, and `instr_valid=0` the next cycle.
- HLT at address 5 (`mem[5]=16'hF000`): after pop, `halted=1` and `imem_req=0` forever. Later redirects are ignored and in-flight words never appear.
- Wrap and async reset: `RESET_PC=16'hFFFE` fetches FFFE, FFFF, 0000. Asserting `rst_n=0` mid-burst clears `instr_valid` immediately.

Source files
------------

// File: rtl/wiscsc15_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode handoff, redirect and halt status.
// master = fetch unit, slave = memory/decode environment.
interface wiscsc15_fetch_if #(
  parameter int PC_W = 16
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [15:0]     imem_rdata;
  logic            instr_valid;
  logic [15:0]     instr;
  logic [PC_W-1:0] instr_pc;
  logic            instr_ready;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            halted;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata,
    output instr_valid, instr, instr_pc,
    input  instr_ready, redirect, redirect_pc,
    output halted
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata,
    input  instr_valid, instr, instr_pc,
    output instr_ready, redirect, redirect_pc,
    input  halted
  );
endinterface

// File: rtl/wiscsc15_fetch.sv
// WISC-SC15 instruction fetch: credit-limited in-order requests, word FIFO to decode, redirect/HLT handling.
// Latency accept->instr_valid is k+1 cycles; requests stall when in-flight + buffered reaches BUF_DEPTH.
module wiscsc15_fetch #(
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  wiscsc15_fetch_if.master  fetch_bus
);
  localparam int            AW      = $clog2(BUF_DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(BUF_DEPTH);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_fetch_pc;
  logic [PC_W-1:0] r_rsp_pc;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_drop;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [15:0]     r_buf_dat [BUF_DEPTH];
  logic [PC_W-1:0] r_buf_pc  [BUF_DEPTH];

  logic          w_run;
  logic          w_credit_ok;
  logic          w_req;
  logic          w_accept;
  logic          w_rsp;
  logic          w_pop;
  logic          w_hlt;
  logic          w_redir;
  logic          w_flush;
  logic          w_push;
  logic [CW-1:0] w_inflight_nxt;

  assign w_run       = (r_state == RUN);
  assign w_credit_ok = ({1'b0, r_inflight} + {1'b0, r_count}) < DEPTH_C;
  assign w_req       = rst_n && w_run && !fetch_bus.redirect && w_credit_ok;
  assign w_accept    = w_req && fetch_bus.imem_ready;
  // A response with nothing outstanding is a memory protocol error; it is ignored.
  assign w_rsp       = fetch_bus.imem_rvalid && (r_inflight != '0);
  assign w_pop       = (r_count != '0) && fetch_bus.instr_ready;
  assign w_hlt       = w_pop && w_run && (r_buf_dat[r_rd_ptr][15:12] == 4'hF);
  assign w_redir     = fetch_bus.redirect && w_run && !w_hlt;
  assign w_flush     = w_hlt || w_redir;
  assign w_push      = w_rsp && (r_drop == '0) && !w_flush && w_run;

  assign w_inflight_nxt = r_inflight + CW'(w_accept) - CW'(w_rsp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        r_buf_dat[i] <= '0;
        r_buf_pc[i]  <= '0;
      end
    end else begin
      r_inflight <= w_inflight_nxt;
      if (w_hlt)
        r_state <= HALT;

      if (w_redir)
        r_fetch_pc <= fetch_bus.redirect_pc;
      else if (w_accept)
        r_fetch_pc <= r_fetch_pc + 1'b1;

      if (w_redir)
        r_rsp_pc <= fetch_bus.redirect_pc;
      else if (w_push)
        r_rsp_pc <= r_rsp_pc + 1'b1;

      // Everything still outstanding after this cycle belongs to the squashed path.
      if (w_flush)
        r_drop <= w_inflight_nxt;
      else if (w_rsp && (r_drop != '0))
        r_drop <= r_drop - 1'b1;

      if (w_flush) begin
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_buf_dat[r_wr_ptr] <= fetch_bus.imem_rdata;
          r_buf_pc[r_wr_ptr]  <= r_rsp_pc;
          r_wr_ptr            <= r_wr_ptr + 1'b1;
        end
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  assign fetch_bus.imem_req    = w_req;
  assign fetch_bus.imem_addr   = r_fetch_pc;
  assign fetch_bus.instr_valid = (r_count != '0);
  assign fetch_bus.instr       = r_buf_dat[r_rd_ptr];
  assign fetch_bus.instr_pc    = r_buf_pc[r_rd_ptr];
  assign fetch_bus.halted      = (r_state == HALT);

  a_rvalid_has_outstanding: assert property (
    @(posedge clk) disable iff (!rst_n) fetch_bus.imem_rvalid |-> (r_inflight != '0)
  );
endmodule

// File: tb/tb_wiscsc15_fetch.sv
// Directed bench for wiscsc15_fetch: streaming, backpressure, redirects, HLT, PC wrap and async reset.
// Memory word at address a is {4'h0, a[11:0]} (opcode 0), except address 5 holds HLT when hlt_en is set.
module tb_wiscsc15_fetch;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  wiscsc15_fetch_if #(.PC_W(16)) f_if ();
  wiscsc15_fetch_if #(.PC_W(16)) w_if ();

  wiscsc15_fetch #(.PC_W(16), .RESET_PC(16'h0000), .BUF_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_bus (f_if.master)
  );

  wiscsc15_fetch #(.PC_W(16), .RESET_PC(16'hFFFE), .BUF_DEPTH(4)) dut_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_bus (w_if.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct { logic [15:0] a; int due; } rsp_t;
  rsp_t        mq[$];
  int          cyc    = 0;
  int          k_lat  = 1;
  bit          hlt_en = 1'b0;
  logic [15:0] got_pc[$];
  logic [15:0] got_ins[$];
  logic [15:0] got2_pc[$];
  logic [15:0] got2_ins[$];
  int          n_req  = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (hlt_en && a == 16'd5) return 16'hF000;
    return {4'h0, a[11:0]};
  endfunction

  function automatic logic [15:0] gpc(input int i);
    return (i < got_pc.size()) ? got_pc[i] : 16'hDEAD;
  endfunction

  function automatic logic [15:0] gins(input int i);
    return (i < got_ins.size()) ? got_ins[i] : 16'hDEAD;
  endfunction

  // Memory for the main DUT: fixed latency k_lat, responses in request order.
  initial begin : mem_main
    f_if.imem_rvalid = 1'b0;
    f_if.imem_rdata  = 16'h0000;
    forever begin
      @(negedge clk);
      cyc++;
      f_if.imem_rvalid = 1'b0;
      if (!rst_n) begin
        mq.delete();
      end else begin
        if (mq.size() > 0 && mq[0].due <= cyc) begin
          f_if.imem_rvalid = 1'b1;
          f_if.imem_rdata  = mem_word(mq[0].a);
          void'(mq.pop_front());
        end
        if (f_if.imem_req && f_if.imem_ready)
          mq.push_back('{a: f_if.imem_addr, due: cyc + k_lat});
      end
    end
  end

  // Memory for the wrap DUT: always ready, one-cycle latency.
  initial begin : mem_wrap
    bit          acc2;
    logic [15:0] a2;
    acc2 = 1'b0;
    a2   = 16'h0000;
    w_if.imem_ready  = 1'b1;
    w_if.instr_ready = 1'b1;
    w_if.redirect    = 1'b0;
    w_if.redirect_pc = 16'h0000;
    w_if.imem_rvalid = 1'b0;
    w_if.imem_rdata  = 16'h0000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        w_if.imem_rvalid = 1'b0;
        acc2 = 1'b0;
      end else begin
        w_if.imem_rvalid = acc2;
        w_if.imem_rdata  = {4'h0, a2[11:0]};
        acc2 = w_if.imem_req;
        a2   = w_if.imem_addr;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (f_if.instr_valid && f_if.instr_ready) begin
          got_pc.push_back(f_if.instr_pc);
          got_ins.push_back(f_if.instr);
        end
        if (f_if.imem_req && f_if.imem_ready) n_req++;
        if (w_if.instr_valid && got2_pc.size() < 3) begin
          got2_pc.push_back(w_if.instr_pc);
          got2_ins.push_back(w_if.instr);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Holds reset for two edges, then releases; returns in cycle 0 one unit after release.
  task automatic start(input int k, input logic ir);
    rst_n = 1'b0;
    k_lat = k;
    f_if.imem_ready  = 1'b1;
    f_if.instr_ready = ir;
    f_if.redirect    = 1'b0;
    f_if.redirect_pc = 16'h0000;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    got_pc.delete();
    got_ins.delete();
    n_req = 0;
    #1;
  endtask

  initial begin : main
    f_if.imem_ready  = 1'b1;
    f_if.instr_ready = 1'b1;
    f_if.redirect    = 1'b0;
    f_if.redirect_pc = 16'h0000;
    #1 rst_n = 1'b0;
    #2;
    check("rst_req",    32'(f_if.imem_req),    32'd0);
    check("rst_addr",   32'(f_if.imem_addr),   32'h0000);
    check("rst_valid",  32'(f_if.instr_valid), 32'd0);
    check("rst_instr",  32'(f_if.instr),       32'h0000);
    check("rst_pc",     32'(f_if.instr_pc),    32'h0000);
    check("rst_halted", 32'(f_if.halted),      32'd0);
    check("rst_addr_w", 32'(w_if.imem_addr),   32'hFFFE);

    // Streaming, k=1: first request in cycle 0, instructions 0,1,2... from cycle 2.
    start(1, 1'b1);
    check("s_req0",   32'(f_if.imem_req),    32'd1);
    check("s_addr0",  32'(f_if.imem_addr),   32'h0000);
    check("s_valid0", 32'(f_if.instr_valid), 32'd0);
    step();
    check("s_valid1", 32'(f_if.instr_valid), 32'd0);
    for (int c = 2; c < 10; c++) begin
      step();
      check("s_valid", 32'(f_if.instr_valid), 32'd1);
      check("s_pc",    32'(f_if.instr_pc),    32'(c - 2));
      check("s_instr", 32'(f_if.instr),       32'(c - 2));
    end
    #1 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(f_if.instr_valid), 32'd0);
    check("ar_req",   32'(f_if.imem_req),    32'd0);

    // Backpressure: decode stalled for 10 cycles, only 4 credits' worth of requests.
    start(1, 1'b0);
    for (int c = 1; c < 10; c++) begin
      step();
      if (c >= 2) check("bp_hold_pc", 32'(f_if.instr_pc), 32'h0000);
    end
    check("bp_nreq",  32'(n_req),            32'd4);
    check("bp_valid", 32'(f_if.instr_valid), 32'd1);
    check("bp_instr", 32'(f_if.instr),       32'h0000);
    f_if.instr_ready = 1'b1;
    repeat (15) step();
    check("bp_count", 32'(got_pc.size() >= 10), 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("bp_seq_pc",  32'(gpc(i)),  32'(i));
      check("bp_seq_ins", 32'(gins(i)), 32'(i));
    end

    // Redirect with two requests in flight, k=3.
    start(3, 1'b1);
    step();
    step();
    f_if.redirect    = 1'b1;
    f_if.redirect_pc = 16'h0040;
    #1;
    check("rd_req_R", 32'(f_if.imem_req), 32'd0);
    step();
    f_if.redirect = 1'b0;
    #1;
    check("rd_req_R1",   32'(f_if.imem_req),    32'd1);
    check("rd_addr_R1",  32'(f_if.imem_addr),   32'h0040);
    check("rd_valid_R1", 32'(f_if.instr_valid), 32'd0);
    repeat (15) step();
    check("rd_pc0",  32'(gpc(0)),  32'h0040);
    check("rd_ins0", 32'(gins(0)), 32'h0040);
    check("rd_pc1",  32'(gpc(1)),  32'h0041);
    check("rd_ins1", 32'(gins(1)), 32'h0041);

    // Redirect coinciding with a pop (pc 3) and a response (addr 4).
    start(1, 1'b1);
    repeat (5) step();
    check("rc_valid", 32'(f_if.instr_valid), 32'd1);
    check("rc_pc",    32'(f_if.instr_pc),    32'h0003);
    f_if.redirect    = 1'b1;
    f_if.redirect_pc = 16'h0080;
    #1;
    check("rc_req_R", 32'(f_if.imem_req), 32'd0);
    step();
    f_if.redirect = 1'b0;
    check("rc_valid_R1", 32'(f_if.instr_valid), 32'd0);
    repeat (10) step();
    check("rc_pc3",  32'(gpc(3)),  32'h0003);
    check("rc_pc4",  32'(gpc(4)),  32'h0080);
    check("rc_ins4", 32'(gins(4)), 32'h0080);
    check("rc_pc5",  32'(gpc(5)),  32'h0081);
    #1 rst_n = 1'b0;
    #1;
    check("ar2_valid", 32'(f_if.instr_valid), 32'd0);
    check("ar2_pc",    32'(f_if.instr_pc),    32'h0000);

    // HLT at address 5: popped in cycle 7, halted from cycle 8, redirects ignored.
    hlt_en = 1'b1;
    start(1, 1'b1);
    repeat (7) step();
    check("h_valid", 32'(f_if.instr_valid), 32'd1);
    check("h_instr", 32'(f_if.instr),       32'hF000);
    check("h_pc",    32'(f_if.instr_pc),    32'h0005);
    step();
    check("h_halted", 32'(f_if.halted),      32'd1);
    check("h_req",    32'(f_if.imem_req),    32'd0);
    check("h_valid2", 32'(f_if.instr_valid), 32'd0);
    f_if.redirect    = 1'b1;
    f_if.redirect_pc = 16'h0040;
    #1;
    check("h_req_redir", 32'(f_if.imem_req), 32'd0);
    step();
    step();
    f_if.redirect = 1'b0;
    repeat (15) step();
    check("h_nreq",    32'(n_req),            32'd8);
    check("h_ndeliv",  32'(got_pc.size()),    32'd6);
    check("h_halted2", 32'(f_if.halted),      32'd1);
    check("h_req2",    32'(f_if.imem_req),    32'd0);
    check("h_valid3",  32'(f_if.instr_valid), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("h_rst_halted", 32'(f_if.halted), 32'd0);
    hlt_en = 1'b0;

    // PC wrap on the RESET_PC=FFFE instance, captured after the first reset release.
    check("w_count", 32'(got2_pc.size() >= 3), 32'd1);
    check("w_pc0",  32'((got2_pc.size()  > 0) ? got2_pc[0]  : 16'hDEAD), 32'hFFFE);
    check("w_pc1",  32'((got2_pc.size()  > 1) ? got2_pc[1]  : 16'hDEAD), 32'hFFFF);
    check("w_pc2",  32'((got2_pc.size()  > 2) ? got2_pc[2]  : 16'hDEAD), 32'h0000);
    check("w_ins0", 32'((got2_ins.size() > 0) ? got2_ins[0] : 16'hDEAD), 32'h0FFE);
    check("w_ins2", 32'((got2_ins.size() > 2) ? got2_ins[2] : 16'hDEAD), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
